arbitro_memoria_vga: RTL and testbench

//  Shares one single-port, synchronous-read data memory (1-cycle read latency) between two requesters:
//  the VGA pixel-fetch path (address counter -> data_dmem) and the CPU load/store port.
//  The VGA read has fixed priority so the scan-out never stalls. A CPU wait counter forces a CPU

---
 rtl/arbitro_memoria_vga.sv | 123 ++++++++++++
 tb/tb_arbitro_memoria_vga.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_vga.sv
// Fixed-priority arbiter sharing one synchronous-read data memory between
// the VGA pixel-fetch path and the CPU load/store port. The CPU is
// guaranteed a slot after CPU_MAX_WAIT denied cycles. Each such forced
// grant steals a VGA fetch and is counted as a VGA miss.
module arbitro_memoria_vga #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CPU_MAX_WAIT = 8,
  parameter int unsigned MISS_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vga_miss,
  output logic [MISS_W-1:0] miss_count
);

  localparam int unsigned WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VGA_RD = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } owner_t;

  owner_t            r_owner;
  owner_t            w_owner_next;
  logic [WAIT_W-1:0] r_cpu_wait;
  logic [MISS_W-1:0] r_miss_count;
  logic              w_force;

  // Grant decision: VGA first unless the CPU has starved long enough.
  // Reset gates every grant so no access leaks out while reset is held.
  always_comb begin
    w_force  = 1'b0;
    cpu_gnt  = 1'b0;
    vga_gnt  = 1'b0;
    vga_miss = 1'b0;
    if (!reset) begin
      w_force  = cpu_req && (r_cpu_wait == WAIT_MAX);
      cpu_gnt  = cpu_req && (!vga_req || w_force);
      vga_gnt  = vga_req && !cpu_gnt;
      vga_miss = w_force && vga_req;
    end
  end

  // Memory port mux: the granted CPU drives the memory, else the VGA reads.
  always_comb begin
    mem_addr  = vga_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  // Owner next state: records which access was issued this cycle.
  always_comb begin
    w_owner_next = IDLE;
    if (vga_gnt) begin
      w_owner_next = VGA_RD;
    end else if (cpu_gnt) begin
      w_owner_next = cpu_we ? CPU_WR : CPU_RD;
    end
  end

  // Owner register: steers the 1-cycle-late read data to its requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= IDLE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // CPU starvation counter: counts denied cycles, saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_wait <= '0;
    end else if (cpu_req && !cpu_gnt) begin
      if (r_cpu_wait != WAIT_MAX) begin
        r_cpu_wait <= r_cpu_wait + WAIT_W'(1);
      end
    end else begin
      r_cpu_wait <= '0;
    end
  end

  // Saturating VGA miss counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_miss_count <= '0;
    end else if (vga_miss && (r_miss_count != '1)) begin
      r_miss_count <= r_miss_count + MISS_W'(1);
    end
  end

  assign vga_rvalid = (r_owner == VGA_RD);
  assign cpu_rvalid = (r_owner == CPU_RD);
  assign vga_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_arbitro_memoria_vga.sv
// Directed bench for arbitro_memoria_vga with a small behavioural memory.
// Expected read data is queued when a grant is expected and consumed when
// the arbiter raises rvalid. A second instance with MISS_W=2 shares the
// stimulus to exercise counter saturation.
module tb_arbitro_memoria_vga;

  logic        clk;
  logic        reset;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [31:0] vga_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        vga_miss;
  logic [7:0]  miss_count;

  logic        vga_gnt_2;
  logic        vga_rvalid_2;
  logic [31:0] vga_rdata_2;
  logic        cpu_gnt_2;
  logic        cpu_rvalid_2;
  logic [31:0] cpu_rdata_2;
  logic [31:0] mem_addr_2;
  logic        mem_we_2;
  logic [31:0] mem_wdata_2;
  logic        vga_miss_2;
  logic [1:0]  miss_count_2;

  logic [31:0] mem [0:1023];
  logic [31:0] vga_q[$];
  logic [31:0] cpu_q[$];

  int errors = 0;
  int checks = 0;

  arbitro_memoria_vga #(
    .ADDR_W(32), .DATA_W(32), .CPU_MAX_WAIT(8), .MISS_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .vga_miss(vga_miss), .miss_count(miss_count)
  );

  arbitro_memoria_vga #(
    .ADDR_W(32), .DATA_W(32), .CPU_MAX_WAIT(8), .MISS_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt_2),
    .vga_rvalid(vga_rvalid_2), .vga_rdata(vga_rdata_2),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt_2), .cpu_rvalid(cpu_rvalid_2),
    .cpu_rdata(cpu_rdata_2), .mem_addr(mem_addr_2), .mem_we(mem_we_2),
    .mem_wdata(mem_wdata_2), .mem_rdata(mem_rdata),
    .vga_miss(vga_miss_2), .miss_count(miss_count_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-data scoreboard: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (vga_rvalid === 1'b1) begin
      if (vga_q.size() == 0) check("vga_rvalid_unexpected", 32'(vga_rvalid), 32'd0);
      else check("vga_rdata", vga_rdata, vga_q.pop_front());
    end
    if (cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
      else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
  end

  // VGA streams from 0x200 while the CPU reads 0x41; the CPU must be
  // forced in on the ninth cycle and then drops its request.
  task automatic contend(input int n_miss);
    logic exp_cg;
    for (int c = 0; c < 10; c++) begin
      vga_req  = 1'b1;
      vga_addr = 32'h200;
      cpu_req  = (c < 9);
      cpu_we   = 1'b0;
      cpu_addr = 32'h41;
      exp_cg   = (c == 8);
      @(negedge clk);
      check("contend_cpu_gnt", 32'(cpu_gnt), 32'(exp_cg));
      check("contend_vga_gnt", 32'(vga_gnt), 32'(!exp_cg));
      check("contend_vga_miss", 32'(vga_miss), 32'(exp_cg));
      if (exp_cg) cpu_q.push_back(32'h42);
      else vga_q.push_back(32'h201);
      if (c == 9) begin
        check("contend_cpu_wait_cleared", 32'(dut.r_cpu_wait), 32'd0);
        check("contend_miss_count", 32'(miss_count), 32'(n_miss));
        check("contend_miss_count_sat", 32'(miss_count_2), 32'((n_miss > 3) ? 3 : n_miss));
      end
      tick();
    end
    vga_req = 1'b0;
    cpu_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);
    reset     = 1'b1;
    vga_req   = 1'b1;
    vga_addr  = 32'h100;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h40;
    cpu_wdata = 32'h1234_5678;

    // Reset with both requesters active: nothing may be issued.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_vga_gnt", 32'(vga_gnt), 32'd0);
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_vga_miss", 32'(vga_miss), 32'd0);
      if (i > 0) begin
        check("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
      end
      tick();
    end
    reset   = 1'b0;
    vga_req = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("post_rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
    check("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    tick();

    // VGA alone: granted every cycle, data one cycle later.
    for (int k = 0; k < 4; k++) begin
      vga_req  = 1'b1;
      vga_addr = 32'h100 + 32'(k);
      @(negedge clk);
      check("vga_only_gnt", 32'(vga_gnt), 32'd1);
      check("vga_only_mem_addr", mem_addr, 32'h100 + 32'(k));
      check("vga_only_mem_we", 32'(mem_we), 32'd0);
      vga_q.push_back(32'h101 + 32'(k));
      tick();
    end
    vga_req = 1'b0;
    @(negedge clk);
    check("vga_only_tail_gnt", 32'(vga_gnt), 32'd0);
    tick();

    // CPU write then read back, no VGA traffic.
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h40;
    cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h40);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
    check("wr_mem_we_off", 32'(mem_we), 32'd0);
    tick();
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    @(negedge clk);
    check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    cpu_q.push_back(32'hDEAD_BEEF);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    tick();

    // Contention and miss counter saturation (second instance is 2 bits).
    for (int n = 1; n <= 5; n++) contend(n);
    tick();
    tick();

    // Reset right after a CPU read grant; the held request must not be
    // regranted and no further rvalid may follow.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h40;
    @(negedge clk);
    check("rstmid_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_q.push_back(32'hDEAD_BEEF);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_gnt_blocked", 32'(cpu_gnt), 32'd0);
    tick();
    @(negedge clk);
    check("rstmid_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rstmid_miss_count", 32'(miss_count), 32'd0);
    tick();
    reset   = 1'b0;
    cpu_req = 1'b0;
    tick();

    check("vga_q_drained", 32'(vga_q.size()), 32'd0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
